// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register ids and status codes
// used by fetch, decode, execute and write-back.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Any status code outside the defined set is reported as an invalid instruction.
    function automatic logic [2:0] norm_stat(input logic [2:0] s);
        if (s >= STAT_AOK && s <= STAT_INS)
            return s;
        return STAT_INS;
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Architectural register file: NREG x DATA_W, two combinational read ports,
// two synchronous write ports where the M port wins on a shared destination.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          NREG     = 15,
    parameter logic [63:0] RSP_INIT = 64'h0000_0200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b,
    output logic [DATA_W-1:0] rsp_val
);

    logic [DATA_W-1:0] regs [NREG];

    // NOTE: the array is small and architecturally defined at reset (%rsp has a
    // non-zero start value), so every entry is reset; large RAMs would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (4'(i) == RRSP) ? RSP_INIT[DATA_W-1:0] : '0;
        end else begin
            // NOTE: non-blocking updates keep same-cycle reads returning the old value.
            for (int i = 0; i < NREG; i++) begin
                if (we_m && dst_m == 4'(i))
                    regs[i] <= val_m;
                else if (we_e && dst_e == 4'(i))
                    regs[i] <= val_e;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] id);
        if (int'(id) < NREG)
            return regs[id];
        return '0;
    endfunction

    assign val_a   = rd(src_a);
    assign val_b   = rd(src_b);
    assign rsp_val = regs[RRSP];

endmodule

// File: rtl/writeback.sv
// SEQ Y86-64 write-back stage: commits valE/valM into the register file,
// latches processor status with sticky halt, and counts retired instructions.
module writeback
    import y86_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          NREG     = 15,
    parameter logic [63:0] RSP_INIT = 64'h0000_0200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [3:0]        icode,
    input  logic [2:0]        stat_in,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] rsp_val,
    output logic [2:0]        stat_out,
    output logic              halted,
    output logic [63:0]       retired
);

    logic [2:0]  stat_q;
    logic        halted_q;
    logic [63:0] retired_q;
    logic [2:0]  stat_n;
    logic        accept;
    logic        commit;

    // icode is carried for status/halt bookkeeping only; status already encodes halt.
    logic unused_icode;
    assign unused_icode = ^icode;

    assign stat_n = norm_stat(stat_in);
    assign accept = wb_valid && !halted_q;
    // A faulting instruction retires and updates status but never writes registers.
    assign commit = accept && (stat_n == STAT_AOK);

    regfile_2r2w #(
        .DATA_W   (DATA_W),
        .NREG     (NREG),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_e    (commit && dstE != RNONE),
        .dst_e   (dstE),
        .val_e   (valE),
        .we_m    (commit && dstM != RNONE),
        .dst_m   (dstM),
        .val_m   (valM),
        .src_a   (srcA),
        .src_b   (srcB),
        .val_a   (valA),
        .val_b   (valB),
        .rsp_val (rsp_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q    <= STAT_AOK;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else if (accept) begin
            stat_q    <= stat_n;
            retired_q <= retired_q + 64'd1;
            if (stat_n != STAT_AOK)
                halted_q <= 1'b1;
        end
    end

    assign stat_out = stat_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule
